// File: rtl/dotp_seq_ctrl_if.sv
// dotp_seq_ctrl_if
// Bundles the control, result handshake, host write and RAM port signals
// of the dot-product sequencer. The master modport is the sequencer side;
// the slave modport is the environment side (host logic, consumer, RAM).
interface dotp_seq_ctrl_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int ACC_WIDTH  = 40
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_a;
  logic [ADDR_WIDTH-1:0] base_b;
  logic [ADDR_WIDTH:0]   len;
  logic                  busy;

  logic [ACC_WIDTH-1:0]  result;
  logic                  result_valid;
  logic                  result_ready;

  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [WIDTH-1:0]      host_din;
  logic                  host_drop;

  logic                  ram_we_a;
  logic                  ram_we_b;
  logic [ADDR_WIDTH-1:0] ram_addr_a;
  logic [ADDR_WIDTH-1:0] ram_addr_b;
  logic [WIDTH-1:0]      ram_din_a;
  logic [WIDTH-1:0]      ram_din_b;
  logic [WIDTH-1:0]      ram_dout_a;
  logic [WIDTH-1:0]      ram_dout_b;

  modport master (
    input  start, base_a, base_b, len, result_ready,
    input  host_we, host_addr, host_din,
    input  ram_dout_a, ram_dout_b,
    output busy, result, result_valid, host_drop,
    output ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b
  );

  modport slave (
    output start, base_a, base_b, len, result_ready,
    output host_we, host_addr, host_din,
    output ram_dout_a, ram_dout_b,
    input  busy, result, result_valid, host_drop,
    input  ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b
  );

endinterface

// File: rtl/dotp_seq_ctrl.sv
// dotp_seq_ctrl
// Owns both ports of the dot-product true-dual-port RAM. In IDLE host writes
// are forwarded to port A; on start, vector A is streamed through port A and
// vector B through port B, the signed products are accumulated, and the sum
// is offered on a valid/ready handshake.
// Optional feature macro: DOTP_SAT_EN -- when defined the accumulator
// saturates (sticky until the next start) instead of wrapping.
module dotp_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128,
  parameter int ACC_WIDTH  = 40
) (
  input logic             clk,
  input logic             rst_n,
  dotp_seq_ctrl_if.master bus_io
);

  localparam int LenW  = ADDR_WIDTH + 1;
  localparam int ProdW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        baseA_q, baseA_d;
  logic [ADDR_WIDTH-1:0]        baseB_q, baseB_d;
  logic [LenW-1:0]              len_q, len_d;
  logic [LenW-1:0]              cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         hostDrop_q, hostDrop_d;

  logic [LenW-1:0]              lenClamp;
  logic signed [ProdW-1:0]      product;
  logic signed [ACC_WIDTH-1:0]  productExt;
  logic signed [ACC_WIDTH-1:0]  accNext;
  logic                         accumulate;

  logic                         ramWeA, ramWeB;
  logic [ADDR_WIDTH-1:0]        ramAddrA, ramAddrB;
  logic [WIDTH-1:0]             ramDinA, ramDinB;

`ifdef DOTP_SAT_EN
  localparam int SumW = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [SumW-1:0]       sumWide;
  logic                         sat_q, sat_d;
  logic                         satHit;
`endif

  // Signed element product, sign-extended to the accumulator width.
  always_comb begin
    lenClamp   = (bus_io.len > LenW'(DEPTH)) ? LenW'(DEPTH) : bus_io.len;
    product    = ProdW'($signed(bus_io.ram_dout_a)) * ProdW'($signed(bus_io.ram_dout_b));
    productExt = ACC_WIDTH'(product);
  end

`ifdef DOTP_SAT_EN
  // Saturating add: clamp on overflow and freeze once a limit has been hit.
  always_comb begin
    sumWide = SumW'(acc_q) + SumW'(productExt);
    satHit  = 1'b0;
    accNext = sumWide[ACC_WIDTH-1:0];
    if (sat_q) begin
      accNext = acc_q;
    end else if (sumWide[SumW-1] != sumWide[SumW-2]) begin
      satHit  = 1'b1;
      accNext = sumWide[SumW-1] ? AccMin : AccMax;
    end
  end
`else
  // Wrapping add modulo 2^ACC_WIDTH.
  always_comb begin
    accNext = acc_q + productExt;
  end
`endif

  // Next-state, RAM port drive and accumulate control.
  always_comb begin
    state_d    = state_q;
    baseA_d    = baseA_q;
    baseB_d    = baseB_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    hostDrop_d = bus_io.host_we && (state_q != IDLE);
    accumulate = 1'b0;
    ramWeA     = 1'b0;
    ramWeB     = 1'b0;
    ramAddrA   = '0;
    ramAddrB   = '0;
    ramDinA    = '0;
    ramDinB    = '0;
`ifdef DOTP_SAT_EN
    sat_d      = sat_q;
`endif

    case (state_q)
      IDLE: begin
        ramWeA   = bus_io.host_we;
        ramAddrA = bus_io.host_addr;
        ramDinA  = bus_io.host_din;
        if (bus_io.start) begin
          baseA_d = bus_io.base_a;
          baseB_d = bus_io.base_b;
          len_d   = lenClamp;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef DOTP_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = (lenClamp == '0) ? DONE : ISSUE;
        end
      end

      ISSUE: begin
        ramAddrA   = baseA_q + cnt_q[ADDR_WIDTH-1:0];
        ramAddrB   = baseB_q + cnt_q[ADDR_WIDTH-1:0];
        accumulate = (cnt_q != '0);
        cnt_d      = cnt_q + LenW'(1);
        if (cnt_q == len_q - LenW'(1)) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        accumulate = 1'b1;
        state_d    = DONE;
      end

      DONE: begin
        if (bus_io.result_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (accumulate) begin
      acc_d = accNext;
`ifdef DOTP_SAT_EN
      sat_d = sat_q | satHit;
`endif
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baseA_q    <= '0;
      baseB_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      hostDrop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baseA_q    <= baseA_d;
      baseB_q    <= baseB_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      hostDrop_q <= hostDrop_d;
    end
  end

`ifdef DOTP_SAT_EN
  // Sticky saturation flag, cleared by reset and by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`endif

  assign bus_io.busy         = (state_q != IDLE);
  assign bus_io.result       = acc_q;
  assign bus_io.result_valid = (state_q == DONE);
  assign bus_io.host_drop    = hostDrop_q;
  assign bus_io.ram_we_a     = ramWeA;
  assign bus_io.ram_we_b     = ramWeB;
  assign bus_io.ram_addr_a   = ramAddrA;
  assign bus_io.ram_addr_b   = ramAddrB;
  assign bus_io.ram_din_a    = ramDinA;
  assign bus_io.ram_din_b    = ramDinB;

endmodule

// File: tb/tb_dotp_seq_ctrl.sv
// tb_dotp_seq_ctrl
// Scoreboard bench for dotp_seq_ctrl. The driver issues host writes and dot
// product jobs, pushing the expected sum and the expected result_valid cycle
// into a queue; the monitor pops on each new result and compares. Other
// checks are posted by the driver into a check queue drained by the monitor.
// Build with DOTP_SAT_EN defined to exercise the saturating accumulator.
module tb_dotp_seq_ctrl;

  localparam int WIDTH      = 16;
  localparam int ADDR_WIDTH = 7;
  localparam int DEPTH      = 128;
  localparam int LenW       = ADDR_WIDTH + 1;
`ifdef DOTP_SAT_EN
  localparam int ACC_WIDTH  = 32;
`else
  localparam int ACC_WIDTH  = 40;
`endif

  typedef struct {
    longint result;
    longint validCycle;
  } exp_t;

  typedef struct {
    string  name;
    longint act;
    longint exp;
  } chk_t;

  logic   clk = 1'b0;
  logic   rst_n;
  longint cyc = 0;
  int     compared = 0;
  int     mismatched = 0;
  int     dropTotal = 0;

  exp_t    sbQ[$];
  chk_t    chkQ[$];
  shortint golden [DEPTH];
  logic [WIDTH-1:0] ram [DEPTH];

  dotp_seq_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  dotp_seq_ctrl #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_io(bus)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural true-dual-port RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (bus.ram_we_a) ram[bus.ram_addr_a] <= bus.ram_din_a;
    if (bus.ram_we_b) ram[bus.ram_addr_b] <= bus.ram_din_b;
    bus.ram_dout_a <= ram[bus.ram_addr_a];
    bus.ram_dout_b <= ram[bus.ram_addr_b];
  end

  // Counts host_drop pulses.
  always @(negedge clk) if (bus.host_drop) dropTotal <= dropTotal + 1;

  // Reference dot product straight from the arithmetic definition.
  function automatic longint refDot(int ba, int bb, int n);
    longint acc = 0;
    longint sum;
`ifdef DOTP_SAT_EN
    bit     sat = 1'b0;
    longint accMax = (longint'(1) <<< (ACC_WIDTH - 1)) - 1;
    longint accMin = -(longint'(1) <<< (ACC_WIDTH - 1));
`endif
    for (int k = 0; k < n; k++) begin
      sum = acc + longint'(golden[(ba + k) % DEPTH]) * longint'(golden[(bb + k) % DEPTH]);
`ifdef DOTP_SAT_EN
      if (!sat) begin
        if (sum > accMax) begin
          acc = accMax;
          sat = 1'b1;
        end else if (sum < accMin) begin
          acc = accMin;
          sat = 1'b1;
        end else begin
          acc = sum;
        end
      end
`else
      acc = (sum <<< (64 - ACC_WIDTH)) >>> (64 - ACC_WIDTH);
`endif
    end
    return acc;
  endfunction

  function automatic void pushCheck(string name, longint act, longint exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chkQ.push_back(c);
  endfunction

  task automatic checkOutput(string name, longint act, longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hostWrite(int addr, shortint data);
    bus.host_we   = 1'b1;
    bus.host_addr = ADDR_WIDTH'(addr);
    bus.host_din  = data;
    @(posedge clk); #1;
    bus.host_we   = 1'b0;
    golden[addr]  = data;
  endtask

  // mode: 0 plain, 1 host write while busy, 2 start while in DONE,
  // 3 host write to base_a in the same cycle as start.
  task automatic applyStimulus(int ba, int bb, int n, int hold, int mode);
    int      pokeAddr = (ba + 1) % DEPTH;
    shortint pokeData = ~golden[(ba + 1) % DEPTH];
    int      dropsBefore;
    int      waited;
    exp_t    e;
    if (mode == 2 && hold < 1) hold = 1;
    waited = 0;
    while (bus.busy && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (mode == 3) begin
      bus.host_we   = 1'b1;
      bus.host_addr = ADDR_WIDTH'(ba);
      bus.host_din  = pokeData;
      golden[ba]    = pokeData;
    end
    e.result     = refDot(ba, bb, n);
    e.validCycle = cyc + ((n == 0) ? 1 : n + 2);
    sbQ.push_back(e);
    bus.start  = 1'b1;
    bus.base_a = ADDR_WIDTH'(ba);
    bus.base_b = ADDR_WIDTH'(bb);
    bus.len    = LenW'(n);
    dropsBefore = dropTotal;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.host_we = 1'b0;
    pushCheck("busy_running", bus.busy, 1);
    if (mode == 1) begin
      bus.host_we   = 1'b1;
      bus.host_addr = ADDR_WIDTH'(pokeAddr);
      bus.host_din  = pokeData;
      @(posedge clk); #1;
      bus.host_we   = 1'b0;
    end
    waited = 0;
    while (!bus.result_valid && waited < n + 8) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.result_valid) pushCheck("valid_timeout", 0, 1);
    for (int h = 0; h < hold; h++) begin
      if (mode == 2 && h == 0) begin
        bus.start  = 1'b1;
        bus.base_a = ADDR_WIDTH'(bb);
        bus.base_b = ADDR_WIDTH'(ba);
        bus.len    = LenW'(1);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    pushCheck("busy_after_ready", bus.busy, 0);
    pushCheck("host_drop_count", dropTotal - dropsBefore, (mode == 1) ? 1 : 0);
    if (mode == 1) pushCheck("ram_untouched", longint'($signed(ram[pokeAddr])), golden[pokeAddr]);
  endtask

  // Monitor: drains posted checks and scores every presented result.
  initial begin : monitor
    exp_t cur;
    bit   haveCur;
    bit   inResult;
    chk_t c;
    logic signed [ACC_WIDTH-1:0] resS;
    haveCur  = 1'b0;
    inResult = 1'b0;
    cur.result = 0;
    cur.validCycle = 0;
    forever begin
      @(negedge clk);
      while (chkQ.size() > 0) begin
        c = chkQ.pop_front();
        checkOutput(c.name, c.act, c.exp);
      end
      if (!rst_n) begin
        inResult = 1'b0;
        haveCur  = 1'b0;
      end else if (bus.result_valid) begin
        if (!inResult) begin
          inResult = 1'b1;
          if (sbQ.size() == 0) begin
            checkOutput("unexpected_result", 1, 0);
            haveCur = 1'b0;
          end else begin
            cur     = sbQ.pop_front();
            haveCur = 1'b1;
            checkOutput("valid_latency", cyc, cur.validCycle);
          end
        end
        if (haveCur) begin
          resS = bus.result;
          checkOutput("result", longint'(resS), cur.result);
        end
        if (bus.result_ready) inResult = 1'b0;
      end else begin
        inResult = 1'b0;
      end
    end
  end

  // Hard stop if the run ever stalls.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Driver: directed scenarios followed by randomized jobs.
  initial begin : driver
    int n;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.base_a       = '0;
    bus.base_b       = '0;
    bus.len          = '0;
    bus.result_ready = 1'b0;
    bus.host_we      = 1'b0;
    bus.host_addr    = '0;
    bus.host_din     = '0;

    @(posedge clk); #1;
    pushCheck("reset_busy", bus.busy, 0);
    pushCheck("reset_result", bus.result, 0);
    pushCheck("reset_valid", bus.result_valid, 0);
    pushCheck("reset_host_drop", bus.host_drop, 0);
    pushCheck("reset_we_b", bus.ram_we_b, 0);
    pushCheck("reset_addr_b", bus.ram_addr_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < DEPTH; a++) hostWrite(a, shortint'($urandom_range(0, 65535)));

    for (int k = 0; k < 4; k++) begin
      hostWrite(k, shortint'(k + 1));
      hostWrite(64 + k, shortint'(k + 5));
    end
    applyStimulus(0, 64, 4, 0, 0);

    applyStimulus(5, 9, 0, 2, 0);

    hostWrite(126, 1); hostWrite(127, 1); hostWrite(0, 1); hostWrite(1, 1);
    for (int k = 10; k < 14; k++) hostWrite(k, 2);
    applyStimulus(126, 10, 4, 0, 0);

    hostWrite(20, -32768);
    hostWrite(30, -32768);
    applyStimulus(20, 30, 1, 5, 2);

    applyStimulus(40, 80, 8, 1, 1);
    applyStimulus(50, 90, 3, 0, 3);

    for (int k = 0; k < 3; k++) begin
      hostWrite(100 + k, -32768);
      hostWrite(110 + k, -32768);
    end
    applyStimulus(100, 110, 3, 1, 0);

    bus.start  = 1'b1;
    bus.base_a = '0;
    bus.base_b = ADDR_WIDTH'(64);
    bus.len    = LenW'(20);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    bus.host_addr = '0;
    bus.host_din  = '0;
    rst_n = 1'b0;
    #1;
    pushCheck("midrst_busy", bus.busy, 0);
    pushCheck("midrst_result", bus.result, 0);
    pushCheck("midrst_valid", bus.result_valid, 0);
    pushCheck("midrst_host_drop", bus.host_drop, 0);
    pushCheck("midrst_we_a", bus.ram_we_a, 0);
    pushCheck("midrst_addr_a", bus.ram_addr_a, 0);
    pushCheck("midrst_addr_b", bus.ram_addr_b, 0);
    pushCheck("midrst_din_b", bus.ram_din_b, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(5, 70, 2, 0, 0);

    for (int it = 0; it < 20; it++) begin
      int nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) begin
        hostWrite(int'($urandom_range(0, DEPTH - 1)), shortint'($urandom_range(0, 65535)));
      end
      n = ($urandom_range(0, 7) == 0) ? DEPTH : int'($urandom_range(0, 40));
      applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                    n, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    pushCheck("scoreboard_empty", sbQ.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
